// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: store op encodings and buffered entry record shared with the load extender
package store_buffer_pkg;
    typedef enum logic [1:0] {
        ST_SW  = 2'd0,
        ST_SH  = 2'd1,
        ST_SB  = 2'd2,
        ST_NOP = 2'd3
    } st_op_e;
    localparam int ENTRY_W = 66;
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_lane_gen.sv
// store_lane_gen: op/addr/data to byte enables and lane-replicated data; misalignment flag when STORE_MISALIGN_CHECK_EN
module store_lane_gen
    import store_buffer_pkg::*;
(
    input  st_op_e      op,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [3:0]  byteen,
    output logic [31:0] wdata,
    output logic        misaligned
);
    // sw takes the whole word, sh/sb replicate their low half/byte across the word
    always_comb begin
        byteen = op == ST_SW ? 4'hF : op == ST_SH ? (addr[1] ? 4'hC : 4'h3) : 4'b0001 << addr;
        wdata  = op == ST_SW ? data : op == ST_SH ? {2{data[15:0]}} : {4{data[7:0]}};
    end
`ifdef STORE_MISALIGN_CHECK_EN
    assign misaligned = (op == ST_SW && addr != 2'b00) || (op == ST_SH && addr[0]);
`else
    assign misaligned = 1'b0;
`endif
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO feeding a bus write port; STORE_MISALIGN_CHECK_EN enables misaligned-store rejection
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    output logic        st_ready,
    output logic        exc_ades,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    input  logic        m_ack,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);
    logic [PW:0]        head_q, head_d, tail_q, tail_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic               exc_q, exc_d;
    logic               full, push, pop, mis;
    logic [3:0]         lane_be;
    logic [31:0]        lane_data;
    sb_entry_t          head_e;
    store_lane_gen u_lane (
        .op         (st_op_e'(st_op)),
        .addr       (st_addr[1:0]),
        .data       (st_wdata),
        .byteen     (lane_be),
        .wdata      (lane_data),
        .misaligned (mis)
    );
    assign empty    = head_q == tail_q;
    assign full     = head_q[PW] != tail_q[PW] && head_q[PW-1:0] == tail_q[PW-1:0];
    assign st_ready = !full;
    assign m_req    = !empty;
    assign exc_ades = exc_q;
    assign head_e   = sb_entry_t'(mem_q[head_q[PW-1:0]]);
    assign m_addr   = m_req ? {head_e.addr, 2'b00} : '0;
    assign m_wdata  = m_req ? head_e.wdata : '0;
    assign m_byteen = m_req ? head_e.byteen : '0;
    // enqueue at tail, dequeue head on ack, and flag rejected misaligned stores
    always_comb begin
        push   = st_valid && st_ready && st_op != ST_NOP && !mis;
        pop    = m_req && m_ack;
        exc_d  = st_valid && st_ready && st_op != ST_NOP && mis;
        head_d = head_q + {{PW{1'b0}}, pop};
        tail_d = tail_q + {{PW{1'b0}}, push};
        mem_d  = mem_q;
        if (push) mem_d[tail_q[PW-1:0]] = {st_addr[31:2], lane_data, lane_be};
    end
    // state registers; reset drops all buffered stores immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            exc_q  <= 1'b0;
            mem_q  <= '{default: '0};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            exc_q  <= exc_d;
            mem_q  <= mem_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus checked against a queue model of the store buffer
module tb_store_buffer;
    localparam int DEPTH = 2;
    logic        clk, reset_n, st_valid, m_ack;
    logic [1:0]  st_op;
    logic [31:0] st_addr, st_wdata;
    logic        st_ready, exc_ades, m_req, empty;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_byteen;
    int          total = 0, bad = 0;
    logic [67:0] q[$];
    logic        exp_exc = 1'b0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_op(st_op),
        .st_addr(st_addr), .st_wdata(st_wdata), .st_ready(st_ready),
        .exc_ades(exc_ades), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byteen(m_byteen), .m_ack(m_ack), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_mis(input logic [1:0] op, input logic [31:0] a);
`ifdef STORE_MISALIGN_CHECK_EN
        return (op == 2'd0 && a[1:0] != 2'b00) || (op == 2'd1 && a[0]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [67:0] model_entry(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        logic [3:0]  be;
        if (op == 2'd0) begin
            w = d;
            be = 4'hF;
        end else if (op == 2'd1) begin
            w = 32'(d[15:0]) * 32'h0001_0001;
            be = a[1] ? 4'hC : 4'h3;
        end else begin
            w = 32'(d[7:0]) * 32'h0101_0101;
            be = 4'b0001 << a[1:0];
        end
        return {a & 32'hFFFF_FFFC, w, be};
    endfunction

    task automatic check_state();
        logic [67:0] h;
        chk("st_ready", st_ready, 32'(q.size() < DEPTH));
        chk("empty", empty, 32'(q.size() == 0));
        chk("m_req", m_req, 32'(q.size() != 0));
        chk("exc_ades", exc_ades, 32'(exp_exc));
        h = q.size() != 0 ? q[0] : 68'd0;
        chk("m_addr", m_addr, h[67:36]);
        chk("m_wdata", m_wdata, h[35:4]);
        chk("m_byteen", m_byteen, 32'(h[3:0]));
    endtask

    task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic ack, output logic acc);
        logic rdy, pp, nexc;
        st_valid = v; st_op = op; st_addr = a; st_wdata = d; m_ack = ack;
        #1 check_state();
        rdy  = q.size() < DEPTH;
        acc  = v && rdy && op != 2'd3 && !is_mis(op, a);
        nexc = v && rdy && op != 2'd3 && is_mis(op, a);
        pp   = q.size() != 0 && ack;
        @(posedge clk);
        #1;
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(model_entry(op, a, d));
        exp_exc = nexc;
    endtask

    initial begin
        logic acc;
        int n;
        reset_n = 1'b0; st_valid = 1'b0; st_op = 2'd0; st_addr = '0; st_wdata = '0; m_ack = 1'b0;
        #12 check_state();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, 2'd2, 32'h0000_0013, 32'h0000_00A5, 0, acc);
        chk("sb_req", m_req, 1);
        chk("sb_addr", m_addr, 32'h0000_0010);
        chk("sb_be", m_byteen, 32'h8);
        chk("sb_data", m_wdata, 32'hA5A5_A5A5);
        repeat (3) cycle(0, 2'd0, 0, 0, 1, acc);
        cycle(1, 2'd1, 32'h0000_0022, 32'h0000_1234, 0, acc);
        for (int i = 0; i < 5; i++) begin
            chk("sh_addr", m_addr, 32'h20);
            chk("sh_be", m_byteen, 32'hC);
            chk("sh_data", m_wdata, 32'h1234_1234);
            cycle(0, 2'd0, 0, 0, 0, acc);
        end
        cycle(0, 2'd0, 0, 0, 1, acc);
        chk("sh_popped", empty, 1);
        cycle(1, 2'd0, 32'h100, 32'h1111_1111, 0, acc);
        cycle(1, 2'd0, 32'h104, 32'h2222_2222, 0, acc);
        chk("sw_full_ready", st_ready, 0);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            n++;
            cycle(1, 2'd0, 32'h108, 32'h3333_3333, 1, acc);
        end
        chk("sw_third_lat", n, 2);
        repeat (4) cycle(0, 2'd0, 0, 0, 1, acc);
        cycle(1, 2'd0, 32'h0000_0006, 32'hDEAD_BEEF, 0, acc);
`ifdef STORE_MISALIGN_CHECK_EN
        chk("mis_exc", exc_ades, 1);
        chk("mis_empty", empty, 1);
        cycle(0, 2'd0, 0, 0, 0, acc);
        chk("mis_exc_once", exc_ades, 0);
`else
        chk("mis_addr", m_addr, 32'h4);
        chk("mis_be", m_byteen, 32'hF);
        chk("mis_exc_tied", exc_ades, 0);
`endif
        repeat (3) cycle(0, 2'd0, 0, 0, 1, acc);
        cycle(1, 2'd0, 32'h300, 32'hAAAA_0001, 0, acc);
        cycle(1, 2'd0, 32'h304, 32'hAAAA_0002, 0, acc);
        chk("rst_pre_req", m_req, 1);
        m_ack = 1'b1;
        reset_n = 1'b0;
        #1;
        q.delete();
        exp_exc = 1'b0;
        check_state();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) cycle(0, 2'd0, 0, 0, 1, acc);
        chk("rst_no_write", m_req, 0);
        cycle(1, 2'd0, 32'h400, 32'h0000_0400, 0, acc);
        cycle(1, 2'd2, 32'h201, 32'h0000_007E, 1, acc);
        chk("same_cyc_occ", empty, 0);
        chk("same_cyc_addr", m_addr, 32'h200);
        chk("same_cyc_be", m_byteen, 32'h2);
        chk("same_cyc_ready", st_ready, 1);
        repeat (3) cycle(0, 2'd0, 0, 0, 1, acc);
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), acc);
        repeat (4) cycle(0, 2'd0, 0, 0, 1, acc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
